// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t       : handshake FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand / sum width
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand and result handshakes of the bit-serial adder.
//   in_valid/in_ready  : operand handshake carrying a, b (and sub)
//   out_valid/out_ready: result handshake carrying sum, cout
//   master : operand source / result sink (testbench or upstream logic)
//   slave  : the adder itself
// Optional: SERIAL_ADDER_SUB_EN adds the sub (a - b) request bit.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit: one-bit combinational full adder.
//   x, y, cin : addend bits and carry in
//   s, co     : sum bit and carry out
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ cin;
  assign co = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one result bit per clock.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   bus     : serial_adder_if.slave (operand and result handshakes)
// Operands are taken in IDLE, summed over WIDTH RUN cycles, and the result
// is held in DONE until out_ready. sum/cout only update on RUN->DONE.
// Optional: SERIAL_ADDER_SUB_EN enables a - b via the sub request bit.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_y, fa_s, fa_co;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  // a - b == a + ~b + 1: invert b bitwise, the +1 comes from the carry seed
  assign fa_y = b_sr[0] ^ sub_q;
`else
  assign fa_y = b_sr[0];
`endif

  full_adder_bit u_fa (
    .x  (a_sr[0]),
    .y  (fa_y),
    .cin(carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift/or so WIDTH=1 needs no special slice.
  assign sum_shift = (sum_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_sr  <= bus.a;
          b_sr  <= bus.b;
          cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_q <= bus.sub;
          carry <= bus.sub;
`else
          carry <= 1'b0;
`endif
          state <= RUN;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift;
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum_q  <= sum_shift;
            cout_q <= fa_co;
            state  <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven plus randomized check of serial_adder
// (WIDTH=8). Inputs are driven and outputs sampled on the falling edge.
module tb_serial_adder;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    int           hold;
    bit           scramble;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = s;
`else
    if (s) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // One full transaction. Called and returning on a falling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, input bit scramble,
                        input logic [W-1:0] es, input logic ec);
    int lat;
    bit seen;
    chk("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; drive_sub(sub); bus.in_valid = 1'b1;
    @(negedge clk);                 // cycle 1: RUN
    bus.in_valid = 1'b0;
    chk("in_ready_in_run", 32'(bus.in_ready), 32'd0);
    lat = 1; seen = 0;
    while (lat < 40) begin
      if (bus.out_valid) begin seen = 1; break; end
      if (scramble) begin
        bus.in_valid = 1'($urandom);
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        drive_sub(1'($urandom));
      end
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("latency", 32'(lat), 32'(W + 1));
    chk("sum", 32'(bus.sum), 32'(es));
    chk("cout", 32'(bus.cout), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sum", 32'(bus.sum), 32'(es));
      chk("hold_cout", 32'(bus.cout), 32'(ec));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);                 // cycle W+2 (+hold): back in IDLE
    bus.out_ready = 1'b0;
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("out_valid_after", 32'(bus.out_valid), 32'd0);
    chk("sum_held_idle", 32'(bus.sum), 32'(es));
    @(negedge clk);                 // in_valid low: must stay idle
    chk("still_idle", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, ms;
    logic rs, mc;

    vecs.push_back('{8'h00, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 5, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h3C, 8'h0F, 1'b0, 0, 1'b1, 8'h4B, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h05, 8'h07, 1'b1, 0, 1'b0, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b1, 0, 1'b0, 8'h02, 1'b1});
    vecs.push_back('{8'h33, 8'h33, 1'b1, 0, 1'b0, 8'h00, 1'b1});
`endif

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    drive_sub(1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].hold, vecs[i].scramble,
             vecs[i].exp_sum, vecs[i].exp_cout);

    // Reset in the 4th RUN cycle abandons the op and clears the result.
    chk("pre_rst_idle", 32'(bus.in_ready), 32'd1);
    bus.a = 8'hC3; bus.b = 8'h11; bus.in_valid = 1'b1;
    @(negedge clk);                 // RUN cycle 1
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);      // RUN cycle 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum", 32'(bus.sum), 32'd0);
    chk("midrst_cout", 32'(bus.cout), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 0, 1'b0, 8'h30, 1'b0);

    // Random operands against plain-arithmetic model.
    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (rs) begin
        ms = W'((int'(ra) - int'(rb) + 256) % 256);
        mc = (ra >= rb);
      end else begin
        ms = W'((int'(ra) + int'(rb)) % 256);
        mc = ((int'(ra) + int'(rb)) > 255);
      end
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), ms, mc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder stage that accepts two WIDTH-bit operands through a valid/ready handshake and adds them LSB-first, one bit per clock. It uses a one-bit full adder and a carry register, then presents the sum and carry-out through a second valid/ready handshake. It sits downstream of the operand source and directly consumes the bitwise sum/carry produced by the one-bit adder cell. It trades WIDTH cycles of latency for a single adder bit.

## Interface
- WIDTH, default 8: operand and sum width in bits; legal range ≥ 1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b (and sub) are valid.
- in_ready  out  1  block can accept operands; equals (state == IDLE).
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- sub  in  1  only present with SERIAL_ADDER_SUB_EN; 1 = compute a − b.
- out_valid  out  1  sum/cout hold a finished result; equals (state == DONE).
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  registered result, a + b mod 2^WIDTH.
- cout  out  1  registered carry out of bit WIDTH−1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1, on the clock edge:
  - a and b load into shift registers a_sr and b_sr.
  - carry ← 0 (or ← sub with the macro), bit counter ← 0, state → RUN.
- RUN: each cycle, the full adder takes a_sr[0], b_sr[0] (XOR sub with the macro), and carry.
  - The sum bit shifts into the MSB of sum_sr; a_sr, b_sr and sum_sr shift right by one.
  - carry ← full-adder carry; counter increments.
  - When counter == WIDTH−1: sum ← final sum_sr, cout ← final carry, state → DONE.
- DONE: out_valid=1. sum and cout stay stable. When out_ready=1: state → IDLE.
- Inputs a, b, sub and in_valid are ignored outside IDLE. out_ready is ignored outside DONE.
- The counter is $clog2(WIDTH+1) bits wide. It never wraps, because it stops at WIDTH−1.
- sum and cout change only on the RUN→DONE edge. They hold the last result otherwise, including across IDLE.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry=0, counter=0. Shift registers are don't-care.
- Latency: if the input handshake completes in cycle 0, out_valid rises in cycle WIDTH+1.
- Throughput:
  - With out_ready held at 1, IDLE returns in cycle WIDTH+2.
  - Minimum spacing between accepted operands is WIDTH+2 cycles.
- Backpressure: out_valid, sum and cout hold indefinitely while out_ready=0.
- Reset mid-operation (RUN or DONE): the operation is abandoned. Next cycle is IDLE, out_valid=0, sum and cout cleared to 0. No partial result is ever presented.
- rst has priority over every handshake in the same cycle.
- WIDTH=1: RUN lasts exactly one cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Port sub exists and is captured with a and b.
  - sub=1 inverts each b bit and seeds carry with 1, giving a − b mod 2^WIDTH.
  - cout=1 means no borrow (a ≥ b, unsigned).
- SERIAL_ADDER_SUB_EN undefined: port sub is absent and the block only adds.

## Structure
- Package serial_adder_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH constant.
- Sub-module full_adder_bit: purely combinational. Inputs x, y, cin; outputs s, co. Instantiated once in the RUN datapath.

## Test plan
All scenarios use WIDTH=8.
- a=0x00, b=0x00 accepted in cycle 0 -> out_valid in cycle 9; sum=0x00, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; with out_ready=1, in_ready returns in cycle 10.
- a=0xA5, b=0x5A; out_ready held 0 for 5 cycles after out_valid -> out_valid, sum=0xFF and cout=0 stay stable; result is accepted when out_ready rises.
- a=0x3C, b=0x0F, with in_valid toggling and a/b changed during RUN -> result still 0x4B, cout=0; no second operation starts.
- rst pulsed in the 4th RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0; a new op a=0x10, b=0x20 then yields 0x30.
- With SERIAL_ADDER_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0. Then a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
